// File: rtl/ddc_pkg.sv
// Shared definitions for the digital down-converter mixer: mode encodings
// and the rounding shift derived from the datapath widths.
package ddc_pkg;

   typedef enum logic [1:0] {
      MODE_MIX  = 2'd0,
      MODE_CONJ = 2'd1,
      MODE_BYP  = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   // Right shift that maps a full-width product onto the output width.
   function automatic int calc_sh(input int sw, input int cw, input int ow);
      return sw + cw - 1 - ow;
   endfunction

endpackage

// File: rtl/ddc_lane_mul.sv
// One mixer lane: registers s*cos and s*sin, then rounds/saturates them
// (or passes the sample through in bypass) and flags clipping.
module ddc_lane_mul
   import ddc_pkg::*;
#(
   parameter int SW = 12,
   parameter int CW = 16,
   parameter int OW = 16
) (
   input  logic                 clk_i,
   input  logic signed [SW-1:0] s_i,
   input  logic signed [CW-1:0] cos_i,
   input  logic signed [CW-1:0] sin_i,
   input  mode_e                mode_i,
   output logic signed [OW-1:0] i_o,
   output logic signed [OW-1:0] q_o,
   output logic                 sat_o
);

   localparam int PW = SW + CW;
   localparam int XW = PW + 1;
   localparam int SH = calc_sh(SW, CW, OW);
   localparam logic signed [XW:0]   HALF = (XW+1)'(1) << (SH - 1);
   localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
   localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

   logic signed [PW-1:0] p_cos_d, p_cos_q, p_sin_d, p_sin_q;
   logic signed [SW-1:0] s_d, s_q;
   logic [OW:0]          ri, rq;

   always_comb begin
      p_cos_d = PW'(s_i) * PW'(cos_i);
      p_sin_d = PW'(s_i) * PW'(sin_i);
      s_d     = s_i;
   end

   always_ff @(posedge clk_i) begin
      p_cos_q <= p_cos_d;
      p_sin_q <= p_sin_d;
      s_q     <= s_d;
   end

   // Returns {clipped, value}; one spare bit keeps the rounding add from wrapping.
   function automatic logic [OW:0] rnd_sat(input logic signed [XW-1:0] x);
      logic signed [XW:0] shr;
      shr = ($signed({x[XW-1], x}) + HALF) >>> SH;
      if (shr > (XW+1)'(OMAX)) return {1'b1, OMAX};
      if (shr < (XW+1)'(OMIN)) return {1'b1, OMIN};
      return {1'b0, shr[OW-1:0]};
   endfunction

   always_comb begin
      ri = rnd_sat(XW'(p_cos_q));
      rq = rnd_sat((mode_i == MODE_CONJ) ? XW'(p_sin_q) : -XW'(p_sin_q));
      if (mode_i == MODE_BYP) begin
         i_o   = OW'(s_q) <<< (OW - SW);
         q_o   = '0;
         sat_o = 1'b0;
      end else begin
         i_o   = ri[OW-1:0];
         q_o   = rq[OW-1:0];
         sat_o = ri[OW] | rq[OW];
      end
   end

endmodule

// File: rtl/ddc_mixer.sv
// Multi-lane complex mixer: aligns samples to oscillator latency, multiplies,
// rounds/saturates to I/Q and counts clipping events.
module ddc_mixer
   import ddc_pkg::*;
#(
   parameter int LANES     = 4,
   parameter int SW        = 12,
   parameter int CW        = 16,
   parameter int OW        = 16,
   parameter int ALIGN_DLY = 14
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [LANES*SW-1:0] smp_i,
   input  logic                smp_valid_i,
   input  logic [LANES*CW-1:0] cos_i,
   input  logic [LANES*CW-1:0] sin_i,
   input  logic                osc_valid_i,
   input  logic [1:0]          mode_i,
   input  logic                sat_clr_i,
   output logic [LANES*OW-1:0] i_o,
   output logic [LANES*OW-1:0] q_o,
   output logic                valid_o,
   output logic [15:0]         sat_cnt_o
);

   localparam int DW = LANES * SW;

   logic [DW-1:0] dly_smp;
   logic          dly_valid;

   generate
      if (ALIGN_DLY == 0) begin : g_nodly
         assign dly_smp   = smp_i;
         assign dly_valid = smp_valid_i;
      end else begin : g_dly
         logic [ALIGN_DLY-1:0][DW-1:0] sr_data_d, sr_data_q;
         logic [ALIGN_DLY-1:0]         sr_valid_d, sr_valid_q;

         always_comb begin
            sr_data_d[0]  = smp_i;
            sr_valid_d[0] = smp_valid_i;
            for (int k = 1; k < ALIGN_DLY; k++) begin
               sr_data_d[k]  = sr_data_q[k-1];
               sr_valid_d[k] = sr_valid_q[k-1];
            end
         end

         // Only the valid bits are reset; stale data is harmless without them.
         always_ff @(posedge clk_i) begin
            if (rst_i) sr_valid_q <= '0;
            else       sr_valid_q <= sr_valid_d;
            sr_data_q <= sr_data_d;
         end

         assign dly_smp   = sr_data_q[ALIGN_DLY-1];
         assign dly_valid = sr_valid_q[ALIGN_DLY-1];
      end
   endgenerate

   mode_e               mode_d, mode_q;
   logic                v1_d, v1_q, valid_d, valid_q, sat_evt;
   logic [LANES*OW-1:0] lane_i, lane_q, i_d, i_q, q_d, q_q;
   logic [LANES-1:0]    lane_sat;
   logic [15:0]         sat_cnt_d, sat_cnt_q;

   always_comb begin
      mode_d = (mode_i == MODE_RSVD) ? MODE_MIX : mode_e'(mode_i);
      v1_d   = dly_valid & (osc_valid_i | (mode_i == MODE_BYP));
   end

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         ddc_lane_mul #(.SW(SW), .CW(CW), .OW(OW)) u_lane (
            .clk_i (clk_i),
            .s_i   (dly_smp[gi*SW +: SW]),
            .cos_i (cos_i[gi*CW +: CW]),
            .sin_i (sin_i[gi*CW +: CW]),
            .mode_i(mode_q),
            .i_o   (lane_i[gi*OW +: OW]),
            .q_o   (lane_q[gi*OW +: OW]),
            .sat_o (lane_sat[gi])
         );
      end
   endgenerate

   always_comb begin
      valid_d   = v1_q;
      i_d       = v1_q ? lane_i : i_q;
      q_d       = v1_q ? lane_q : q_q;
      sat_evt   = v1_q & (|lane_sat);
      sat_cnt_d = sat_cnt_q;
      if (sat_clr_i)
         sat_cnt_d = sat_evt ? 16'd1 : 16'd0;
      else if (sat_evt && sat_cnt_q != 16'hFFFF)
         sat_cnt_d = sat_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q    <= MODE_MIX;
         v1_q      <= 1'b0;
         valid_q   <= 1'b0;
         i_q       <= '0;
         q_q       <= '0;
         sat_cnt_q <= '0;
      end else begin
         mode_q    <= mode_d;
         v1_q      <= v1_d;
         valid_q   <= valid_d;
         i_q       <= i_d;
         q_q       <= q_d;
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign i_o       = i_q;
   assign q_o       = q_q;
   assign valid_o   = valid_q;
   assign sat_cnt_o = sat_cnt_q;

endmodule

// File: tb/tb_ddc_mixer.sv
// Self-checking bench for ddc_mixer: directed phases plus random traffic,
// compared every cycle against a cycle-indexed arithmetic reference model.
module tb_ddc_mixer;

   localparam int D    = 14;
   localparam int NMAX = 2048;

   logic        clk_i = 1'b0;
   logic        rst_i, smp_valid_i, osc_valid_i, sat_clr_i, valid_o;
   logic [47:0] smp_i;
   logic [63:0] cos_i, sin_i, i_o, q_o;
   logic [1:0]  mode_i;
   logic [15:0] sat_cnt_o;

   always #5 clk_i = ~clk_i;

   ddc_mixer #(.LANES(4), .SW(12), .CW(16), .OW(16), .ALIGN_DLY(D)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .smp_i      (smp_i),
      .smp_valid_i(smp_valid_i),
      .cos_i      (cos_i),
      .sin_i      (sin_i),
      .osc_valid_i(osc_valid_i),
      .mode_i     (mode_i),
      .sat_clr_i  (sat_clr_i),
      .i_o        (i_o),
      .q_o        (q_o),
      .valid_o    (valid_o),
      .sat_cnt_o  (sat_cnt_o)
   );

   // Input history, indexed by the clock edge that samples it.
   bit          rst_h[NMAX], sv_h[NMAX], osc_h[NMAX], clr_h[NMAX];
   logic [1:0]  mode_h[NMAX];
   logic [47:0] smp_h[NMAX];
   logic [63:0] cos_h[NMAX], sin_h[NMAX];

   int          n = 0;
   int          n_checks = 0, n_pass = 0;
   int          first_in = 0, first_v = -1;
   bit          m_v;
   logic [63:0] m_i, m_q;
   int          m_cnt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got %h expected %h", tag, n, got, exp);
   endtask

   function automatic longint sx(input longint v, input int w);
      if (v >= (longint'(1) << (w - 1))) return v - (longint'(1) << w);
      return v;
   endfunction

   // Round half up after dividing by 2^11, then clip to 16-bit signed.
   function automatic longint rnd_clip(input longint x, output bit clip);
      longint t, y;
      t = x + 1024;
      if (t >= 0) y = t / 2048;
      else        y = -((-t + 2047) / 2048);
      clip = 1'b0;
      if (y > 32767)       begin y = 32767;  clip = 1'b1; end
      else if (y < -32768) begin y = -32768; clip = 1'b1; end
      return y;
   endfunction

   task automatic model_step();
      int     src;
      bit     v, evt, ci, cq;
      longint s, c, sn, iv, qv;
      logic [11:0] ws;
      logic [15:0] wc, wsn;
      if (rst_h[n]) begin
         m_v = 1'b0; m_i = '0; m_q = '0; m_cnt = 0;
         return;
      end
      src = n - 1 - D;
      v   = (src >= 0) && sv_h[src] && (osc_h[n-1] || mode_h[n-1] == 2'd2);
      if (v) for (int j = src; j < n; j++) if (rst_h[j]) v = 1'b0;
      evt = 1'b0;
      if (v) begin
         for (int l = 0; l < 4; l++) begin
            ws  = smp_h[src][l*12 +: 12];
            wc  = cos_h[n-1][l*16 +: 16];
            wsn = sin_h[n-1][l*16 +: 16];
            s   = sx(longint'(ws), 12);
            c   = sx(longint'(wc), 16);
            sn  = sx(longint'(wsn), 16);
            ci  = 1'b0; cq = 1'b0;
            if (mode_h[n-1] == 2'd2) begin
               iv = s * 16; qv = 0;
            end else begin
               iv = rnd_clip(s * c, ci);
               qv = (mode_h[n-1] == 2'd1) ? rnd_clip(s * sn, cq) : rnd_clip(-(s * sn), cq);
            end
            evt = evt | ci | cq;
            m_i[l*16 +: 16] = iv[15:0];
            m_q[l*16 +: 16] = qv[15:0];
         end
      end
      m_v = v;
      if (clr_h[n])                 m_cnt = evt ? 1 : 0;
      else if (evt && m_cnt < 65535) m_cnt++;
   endtask

   task automatic run_cycle(input bit rst, input bit sv, input bit osc, input logic [1:0] mode,
                            input bit clr, input logic [47:0] smp, input logic [63:0] c,
                            input logic [63:0] s);
      rst_i = rst; smp_valid_i = sv; osc_valid_i = osc; mode_i = mode;
      sat_clr_i = clr; smp_i = smp; cos_i = c; sin_i = s;
      rst_h[n] = rst; sv_h[n] = sv; osc_h[n] = osc; mode_h[n] = mode;
      clr_h[n] = clr; smp_h[n] = smp; cos_h[n] = c; sin_h[n] = s;
      @(posedge clk_i);
      #1;
      model_step();
      check("valid_o", 64'(valid_o), 64'(m_v));
      check("i_o", i_o, m_i);
      check("q_o", q_o, m_q);
      check("sat_cnt_o", 64'(sat_cnt_o), 64'(m_cnt));
      if (first_v < 0 && valid_o) first_v = n;
      n++;
   endtask

   function automatic logic [47:0] rep12(input logic [11:0] v);
      return {4{v}};
   endfunction

   function automatic logic [63:0] rep16(input logic [15:0] v);
      return {4{v}};
   endfunction

   function automatic logic [47:0] rnd_smp();
      logic [47:0] w;
      for (int l = 0; l < 4; l++)
         case ($urandom % 4)
            0:       w[l*12 +: 12] = 12'h800;
            1:       w[l*12 +: 12] = 12'h7FF;
            default: w[l*12 +: 12] = 12'($urandom);
         endcase
      return w;
   endfunction

   function automatic logic [63:0] rnd_osc();
      logic [63:0] w;
      for (int l = 0; l < 4; l++)
         case ($urandom % 4)
            0:       w[l*16 +: 16] = 16'h8000;
            1:       w[l*16 +: 16] = 16'h7FFF;
            default: w[l*16 +: 16] = 16'($urandom);
         endcase
      return w;
   endfunction

   initial begin
      logic [47:0] s_sat;
      logic [63:0] c_sat;
      s_sat = rep12(12'h800);
      c_sat = rep16(16'h8000);

      for (int k = 0; k < 3; k++) run_cycle(1, 0, 0, 2'd0, 0, '0, '0, '0);
      $display("reset phase done, cycle %0d", n);

      first_in = n; first_v = -1;
      for (int k = 0; k < 40; k++)
         run_cycle(0, 1, 1, 2'd0, 0, rep12(12'd1024), rep16(16'd16384), '0);
      check("first_valid_latency", 64'(first_v - first_in + 1), 64'd16);
      check("mix_i_8192", i_o, rep16(16'd8192));
      check("mix_q_0", q_o, 64'd0);
      $display("mix phase done, cycle %0d", n);

      for (int k = 0; k < 30; k++) run_cycle(0, 1, 1, 2'd0, 0, s_sat, c_sat, c_sat);
      check("sat_i_max", i_o, rep16(16'h7FFF));
      check("sat_q_min", q_o, rep16(16'h8000));
      $display("saturation phase done, cycle %0d", n);

      for (int k = 0; k < 30; k++)
         run_cycle(0, 1, 1, 2'd1, 0, rep12(12'd1000), '0, rep16(16'hC000));
      check("conj_q_m8000", q_o, rep16(16'hE0C0));
      for (int k = 0; k < 30; k++)
         run_cycle(0, 1, 1, 2'd0, 0, rep12(12'd1000), '0, rep16(16'hC000));
      check("mix_q_p8000", q_o, rep16(16'd8000));
      $display("conjugate/mix phase done, cycle %0d", n);

      for (int k = 0; k < 40; k++)
         run_cycle(0, (k % 3) != 2, 0, 2'd2, 0, rep12(12'hFFB), rnd_osc(), rnd_osc());
      check("byp_i_m80", i_o, rep16(16'hFFB0));
      check("byp_q_0", q_o, 64'd0);
      $display("bypass phase done, cycle %0d", n);

      for (int k = 0; k < 40; k++)
         run_cycle(0, 1, !(k >= 20 && k < 23), 2'd0, 0, rnd_smp(), rnd_osc(), rnd_osc());
      $display("oscillator gap phase done, cycle %0d", n);

      for (int k = 0; k < 50; k++)
         run_cycle(k == 10, 1, 1, 2'd0, 0, s_sat, c_sat, c_sat);
      $display("mid-stream reset phase done, cycle %0d", n);

      for (int k = 0; k < 30; k++)
         run_cycle(0, 1, 1, 2'd0, k == 25, s_sat, c_sat, c_sat);
      for (int k = 0; k < 20; k++)
         run_cycle(0, 0, 1, 2'd0, k == 18, s_sat, c_sat, c_sat);
      $display("saturation clear phase done, cycle %0d", n);

      for (int k = 0; k < 600; k++)
         run_cycle(($urandom % 150) == 0, ($urandom % 4) != 0, ($urandom % 8) != 0,
                   2'($urandom), ($urandom % 40) == 0, rnd_smp(), rnd_osc(), rnd_osc());
      $display("random phase done, cycle %0d", n);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
